// File: rtl/jtkcpu_alu_seq_pkg.sv
// Shared definitions for the ALU sequencer and the decode unit:
// opcodes, CC bit positions, op classes and sequencer state encodings.
package jtkcpu_alu_seq_pkg;

   // Opcodes handled by the ALU path
   localparam logic [7:0] OP_LDA_IMM  = 8'h01;
   localparam logic [7:0] OP_ADDA_IMM = 8'h02;
   localparam logic [7:0] OP_CMPA_IMM = 8'h03;
   localparam logic [7:0] OP_ASRD_IMM = 8'h40;
   localparam logic [7:0] OP_LSRD_IMM = 8'h41;
   localparam logic [7:0] OP_RORD_IMM = 8'h42;
   localparam logic [7:0] OP_ROLD_IMM = 8'h43;
   localparam logic [7:0] OP_ASLD_IMM = 8'h44;
   localparam logic [7:0] OP_ASRD_IDX = 8'h48;
   localparam logic [7:0] OP_LSRD_IDX = 8'h49;
   localparam logic [7:0] OP_RORD_IDX = 8'h4A;
   localparam logic [7:0] OP_ROLD_IDX = 8'h4B;
   localparam logic [7:0] OP_ASLD_IDX = 8'h4C;
   localparam logic [7:0] OP_DIVX     = 8'h60;
   localparam logic [7:0] OP_DIVD     = 8'h61;

   // CC bit positions; ALU flags {h,n,z,v,c} map onto bits 4:0
   localparam int CC_C = 0;
   localparam int CC_V = 1;
   localparam int CC_Z = 2;
   localparam int CC_N = 3;
   localparam int CC_H = 4;

   // Op classes
   localparam logic [1:0] OPC_SINGLE = 2'd0;
   localparam logic [1:0] OPC_ITER   = 2'd1;
   localparam logic [1:0] OPC_DIV    = 2'd2;

   // Sequencer states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SINGLE = 3'd1;
   localparam logic [2:0] ST_ITER   = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/jtkcpu_alu_cls.sv
// Opcode to op-class decoder, shared with the decode unit.
// Anything not recognised is treated as a single-step op.
module jtkcpu_alu_cls
   import jtkcpu_alu_seq_pkg::*;
(
   input  logic [7:0] op,
   output logic [1:0] cls
);

   // Classify shifts/rotates as iterated and divides as multi-cycle
   always_comb begin
      cls = OPC_SINGLE;
      case (op)
         OP_ASRD_IMM, OP_LSRD_IMM, OP_RORD_IMM,
         OP_ROLD_IMM, OP_ASLD_IMM,
         OP_ASRD_IDX, OP_LSRD_IDX, OP_RORD_IDX,
         OP_ROLD_IDX, OP_ASLD_IDX: cls = OPC_ITER;
         OP_DIVX, OP_DIVD:          cls = OPC_DIV;
         default:                   cls = OPC_SINGLE;
      endcase
   end

endmodule

// File: rtl/jtkcpu_alu_seq.sv
// Sequencer in front of jtkcpu_alu: issues one request at a time,
// steps shifts bit by bit, waits on the divider, returns result + CC.
module jtkcpu_alu_seq
   import jtkcpu_alu_seq_pkg::*;
#(
   parameter int CNTW    = 8,
   parameter int DIV_TMO = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cen,
   input  logic            req,
   output logic            ready,
   input  logic [7:0]      op,
   input  logic [15:0]     opnd0,
   input  logic [15:0]     opnd1,
   input  logic [7:0]      cc_in,
   input  logic [CNTW-1:0] cnt,
   output logic [7:0]      alu_op,
   output logic [15:0]     alu_opnd0,
   output logic [15:0]     alu_opnd1,
   output logic [7:0]      alu_cc,
   input  logic [15:0]     alu_rslt,
   input  logic [4:0]      alu_flags,
   input  logic            alu_busy,
   output logic            done,
   output logic [15:0]     rslt,
   output logic [7:0]      cc_out,
   output logic            err
);

   localparam int TW = $clog2(DIV_TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TMO - 1);

   logic [2:0]      st_q,    st_d;
   logic [7:0]      op_q,    op_d;
   logic [15:0]     acc_q,   acc_d;
   logic [15:0]     opb_q,   opb_d;
   logic [7:0]      ccw_q,   ccw_d;
   logic [CNTW-1:0] rem_q,   rem_d;
   logic [TW-1:0]   tmo_q,   tmo_d;
   logic [15:0]     rslt_q,  rslt_d;
   logic [7:0]      cco_q,   cco_d;
   logic            err_q,   err_d;
   logic [1:0]      cls;

   jtkcpu_alu_cls u_cls (
      .op  (op),
      .cls (cls)
   );

   assign ready     = (st_q == ST_IDLE);
   assign done      = (st_q == ST_DONE);
   assign alu_op    = op_q;
   assign alu_opnd0 = acc_q;
   assign alu_opnd1 = opb_q;
   assign alu_cc    = ccw_q;
   assign rslt      = rslt_q;
   assign cc_out    = cco_q;
   assign err       = err_q;

   // Next-state and datapath updates for one cen step
   always_comb begin
      st_d   = st_q;
      op_d   = op_q;
      acc_d  = acc_q;
      opb_d  = opb_q;
      ccw_d  = ccw_q;
      rem_d  = rem_q;
      tmo_d  = tmo_q;
      rslt_d = rslt_q;
      cco_d  = cco_q;
      err_d  = err_q;
      case (st_q)
         ST_IDLE: begin
            if (req) begin
               op_d  = op;
               acc_d = opnd0;
               opb_d = opnd1;
               ccw_d = cc_in;
               rem_d = cnt;
               tmo_d = '0;
               case (cls)
                  OPC_ITER: st_d = ST_ITER;
                  OPC_DIV:  st_d = ST_WAIT;
                  default:  st_d = ST_SINGLE;
               endcase
            end
         end
         ST_SINGLE: begin
            rslt_d = alu_rslt;
            cco_d  = {ccw_q[7:5], alu_flags};
            err_d  = 1'b0;
            st_d   = ST_DONE;
         end
         ST_ITER: begin
            if (rem_q != '0) begin
               acc_d = alu_rslt;
               ccw_d = {ccw_q[7:5], alu_flags};
               rem_d = rem_q - 1'b1;
            end else begin
               rslt_d = acc_q;
               cco_d  = ccw_q;
               err_d  = 1'b0;
               st_d   = ST_DONE;
            end
         end
         ST_WAIT: begin
            // first WAIT cycle ignores busy: the divider has not started yet
            tmo_d = tmo_q + 1'b1;
            if (tmo_q != '0 && !alu_busy) begin
               rslt_d = alu_rslt;
               cco_d  = {ccw_q[7:5], alu_flags};
               err_d  = 1'b0;
               st_d   = ST_DONE;
            end else if (tmo_q == TMO_LAST) begin
               rslt_d       = acc_q;
               cco_d        = ccw_q;
               cco_d[CC_V]  = 1'b1;
               err_d        = 1'b1;
               st_d         = ST_DONE;
            end
         end
         ST_DONE: st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase
   end

   // State registers advance only on cen edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= ST_IDLE;
         op_q   <= '0;
         acc_q  <= '0;
         opb_q  <= '0;
         ccw_q  <= '0;
         rem_q  <= '0;
         tmo_q  <= '0;
         rslt_q <= '0;
         cco_q  <= '0;
         err_q  <= 1'b0;
      end else if (cen) begin
         st_q   <= st_d;
         op_q   <= op_d;
         acc_q  <= acc_d;
         opb_q  <= opb_d;
         ccw_q  <= ccw_d;
         rem_q  <= rem_d;
         tmo_q  <= tmo_d;
         rslt_q <= rslt_d;
         cco_q  <= cco_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_jtkcpu_alu_seq.sv
// Directed bench for jtkcpu_alu_seq with a small behavioural ALU
// answering the sequencer's alu_* requests.
module tb_jtkcpu_alu_seq;
   import jtkcpu_alu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cen = 1'b1;
   logic        req = 1'b0;
   logic        ready;
   logic [7:0]  op = '0;
   logic [15:0] opnd0 = '0;
   logic [15:0] opnd1 = '0;
   logic [7:0]  cc_in = '0;
   logic [7:0]  cnt = '0;
   logic [7:0]  alu_op;
   logic [15:0] alu_opnd0;
   logic [15:0] alu_opnd1;
   logic [7:0]  alu_cc;
   logic [15:0] alu_rslt;
   logic [4:0]  alu_flags;
   logic        alu_busy = 1'b0;
   logic        done;
   logic [15:0] rslt;
   logic [7:0]  cc_out;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;
   bit cen_div = 1'b0;
   int ph = 0;

   jtkcpu_alu_seq #(.CNTW(8), .DIV_TMO(32)) dut (
      .clk(clk), .rst(rst), .cen(cen), .req(req), .ready(ready),
      .op(op), .opnd0(opnd0), .opnd1(opnd1), .cc_in(cc_in),
      .cnt(cnt), .alu_op(alu_op), .alu_opnd0(alu_opnd0),
      .alu_opnd1(alu_opnd1), .alu_cc(alu_cc),
      .alu_rslt(alu_rslt), .alu_flags(alu_flags),
      .alu_busy(alu_busy), .done(done), .rslt(rslt),
      .cc_out(cc_out), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: flags packed {h,n,z,v,c}
   logic [8:0] s9;
   always_comb begin
      s9        = '0;
      alu_rslt  = alu_opnd0;
      alu_flags = alu_cc[4:0];
      case (alu_op)
         OP_ADDA_IMM: begin
            s9 = {1'b0, alu_opnd0[7:0]} + {1'b0, alu_opnd1[7:0]};
            alu_rslt = {8'h00, s9[7:0]};
            alu_flags[4] = ({1'b0, alu_opnd0[3:0]} +
                            {1'b0, alu_opnd1[3:0]}) > 5'd15;
            alu_flags[3] = s9[7];
            alu_flags[2] = (s9[7:0] == 8'h00);
            alu_flags[1] = (alu_opnd0[7] == alu_opnd1[7]) &&
                           (s9[7] != alu_opnd0[7]);
            alu_flags[0] = s9[8];
         end
         OP_LSRD_IMM: begin
            alu_rslt = {1'b0, alu_opnd0[15:1]};
            alu_flags[3] = 1'b0;
            alu_flags[2] = (alu_rslt == 16'h0);
            alu_flags[0] = alu_opnd0[0];
         end
         OP_RORD_IMM: begin
            alu_rslt = {alu_cc[0], alu_opnd0[15:1]};
            alu_flags[3] = alu_rslt[15];
            alu_flags[2] = (alu_rslt == 16'h0);
            alu_flags[0] = alu_opnd0[0];
         end
         OP_DIVX: begin
            alu_rslt = (alu_opnd1 != 0) ? alu_opnd0 / alu_opnd1 : 16'h0;
            alu_flags[3] = alu_rslt[15];
            alu_flags[2] = (alu_rslt == 16'h0);
            alu_flags[1] = 1'b0;
            alu_flags[0] = 1'b0;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; reports whether that edge was a cen edge
   task automatic tick(output bit was_en);
      was_en = cen;
      @(posedge clk);
      #1;
      if (cen_div) begin
         ph  = (ph + 1) % 4;
         cen = (ph == 0);
      end else begin
         cen = 1'b1;
      end
   endtask

   task automatic start(input logic [7:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] c,
                        input logic [7:0] n, input int busy_n);
      bit e;
      op = o; opnd0 = a; opnd1 = b; cc_in = c; cnt = n;
      alu_busy = (busy_n > 0);
      ph = 0; cen = 1'b1; req = 1'b1;
      tick(e);
      req = 1'b0;
      op = 8'hFF; opnd0 = 16'hDEAD; cc_in = 8'h5A; cnt = 8'hEE;
   endtask

   // Issue an op and return the number of cen edges after E0 to done
   task automatic run_op(input logic [7:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] c,
                         input logic [7:0] n, input int busy_n,
                         output int lat);
      bit e;
      int t;
      start(o, a, b, c, n, busy_n);
      lat = 0; t = 0;
      while (!done && t < 400) begin
         tick(e);
         t++;
         if (e) begin
            lat++;
            if (lat >= busy_n) alu_busy = 1'b0;
         end
      end
   endtask

   initial begin
      int  lat, hi_ticks, en_edges, seen;
      bit  e;
      #12;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_rslt", rslt, 0);
      check("rst_alu_op", alu_op, 0);
      rst = 1'b1;
      tick(e);

      // 1: ADDA overflow
      run_op(OP_ADDA_IMM, 16'h007F, 16'h0001, 8'h00, 8'd0, 0, lat);
      check("add_lat", lat, 1);
      check("add_rslt", rslt, 16'h0080);
      check("add_cc", cc_out, 8'h1A);
      check("add_rdy_in_done", ready, 0);
      tick(e);
      check("add_done_drop", done, 0);
      check("add_ready_back", ready, 1);

      // 2: LSRD by 3
      run_op(OP_LSRD_IMM, 16'h8001, 16'h0, 8'h00, 8'd3, 0, lat);
      check("lsr_lat", lat, 4);
      check("lsr_rslt", rslt, 16'h1000);
      check("lsr_cc", cc_out, 8'h00);
      tick(e);

      // 3: RORD with cnt=0 passes operand and CC through
      run_op(OP_RORD_IMM, 16'h1234, 16'h0, 8'hA5, 8'd0, 0, lat);
      check("ror0_lat", lat, 1);
      check("ror0_rslt", rslt, 16'h1234);
      check("ror0_cc", cc_out, 8'hA5);
      tick(e);

      // 5: cen 1:3 during LSRD by 5
      cen_div = 1'b1;
      run_op(OP_LSRD_IMM, 16'hFFFF, 16'h0, 8'h00, 8'd5, 0, lat);
      check("cen_lat", lat, 6);
      check("cen_rslt", rslt, 16'h07FF);
      check("cen_cc", cc_out, 8'h01);
      hi_ticks = 0; en_edges = 0;
      while (done && hi_ticks < 20) begin
         tick(e);
         hi_ticks++;
         if (e) en_edges++;
      end
      check("cen_done_en_edges", en_edges, 1);
      check("cen_done_ticks", hi_ticks, 4);
      cen_div = 1'b0;
      tick(e);

      // 4a: divide, busy high for 10 cen cycles
      run_op(OP_DIVX, 16'd100, 16'd7, 8'hE2, 8'd0, 10, lat);
      check("div_lat", lat, 11);
      check("div_rslt", rslt, 16'h000E);
      check("div_cc", cc_out, 8'hE0);
      check("div_err", err, 0);
      tick(e);

      // 4b: divide with busy stuck high -> timeout
      run_op(OP_DIVX, 16'h1234, 16'd3, 8'h04, 8'd0, 1000, lat);
      check("tmo_lat", lat, 32);
      check("tmo_rslt", rslt, 16'h1234);
      check("tmo_cc", cc_out, 8'h06);
      check("tmo_err", err, 1);
      alu_busy = 1'b0;
      tick(e);

      // 6: reset in the middle of an iterated op
      start(OP_LSRD_IMM, 16'hF0F0, 16'h0, 8'h0F, 8'd8, 0);
      tick(e); tick(e); tick(e);
      rst = 1'b0;
      #1;
      check("mid_rst_ready", ready, 1);
      check("mid_rst_done", done, 0);
      check("mid_rst_rslt", rslt, 0);
      check("mid_rst_cc", cc_out, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_alu_op", alu_op, 0);
      check("mid_rst_alu_a", alu_opnd0, 0);
      check("mid_rst_alu_b", alu_opnd1, 0);
      check("mid_rst_alu_cc", alu_cc, 0);
      tick(e); tick(e);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick(e);
         if (done) seen++;
      end
      check("mid_rst_no_done", seen, 0);
      run_op(OP_ADDA_IMM, 16'h0011, 16'h0022, 8'h00, 8'd0, 0, lat);
      check("post_rst_lat", lat, 1);
      check("post_rst_rslt", rslt, 16'h0033);
      check("post_rst_cc", cc_out, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
